// File: rtl/fpga_bram_responder.sv
// Line-oriented BRAM slave: 8-word line writes (gaps allowed) and fixed-latency
// 8-beat line reads over a shared address/data bus, with protocol error pulses.
module fpga_bram_responder #(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address_data_bus_c_to_m,
   input  logic        address_on_c_to_m,
   input  logic        data_on_c_to_m,
   input  logic        read_en_c_to_m,
   input  logic        write_en_c_to_m,
   output logic [31:0] address_data_bus_m_to_c,
   output logic        resp_m_to_c,
   output logic        error
);

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam int unsigned LW       = AW - 3;
   localparam int unsigned WAIT_CYC = (READ_LATENCY > 2) ? READ_LATENCY - 2 : 0;

   typedef enum logic [2:0] {IDLE, WR_DATA, WR_ACK, RD_WAIT, RD_BURST} state_e;

   state_e              state_q, state_d;
   logic [3:0]          beat_q, beat_d;
   logic [2:0]          lat_q, lat_d;
   logic [LW-1:0]       line_q, line_d;
   logic                rd_vld_q, rd_vld_d;
   logic                resp_q, resp_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                error_q, error_d;
   logic [DATA_W-1:0]   mem_rd_q;
   logic [DATA_W-1:0]   mem [DEPTH_WORDS];

   logic                we_c, rd_en_c, req_ok_c;
   logic [AW-1:0]       waddr_c, raddr_c;
   logic [LW-1:0]       line_c;

   assign line_c   = address_data_bus_c_to_m[AW+1:5];
   assign req_ok_c = address_on_c_to_m && !data_on_c_to_m &&
                     (read_en_c_to_m ^ write_en_c_to_m);

   // Next-state, storage strobes and registered-output values
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      lat_d   = lat_q;
      line_d  = line_q;
      we_c    = 1'b0;
      rd_en_c = 1'b0;
      waddr_c = {line_q, beat_q[2:0]};
      raddr_c = {line_q, beat_q[2:0]};
      resp_d  = rd_vld_q;
      rdata_d = rd_vld_q ? mem_rd_q : '0;
      error_d = (address_on_c_to_m &&
                 (state_q != IDLE || !(read_en_c_to_m ^ write_en_c_to_m))) ||
                (data_on_c_to_m && (state_q == IDLE || address_on_c_to_m));

      case (state_q)
         IDLE: begin
            if (req_ok_c) begin
               line_d = line_c;
               beat_d = 4'd0;
               if (write_en_c_to_m) begin
                  state_d = WR_DATA;
               end else if (READ_LATENCY == 1) begin
                  // Latency 1 needs the first array read issued in the accept cycle
                  rd_en_c = 1'b1;
                  raddr_c = {line_c, 3'd0};
                  beat_d  = 4'd1;
                  state_d = RD_BURST;
               end else if (WAIT_CYC == 0) begin
                  state_d = RD_BURST;
               end else begin
                  lat_d   = 3'(WAIT_CYC);
                  state_d = RD_WAIT;
               end
            end
         end
         WR_DATA: begin
            if (data_on_c_to_m && !address_on_c_to_m) begin
               we_c   = 1'b1;
               beat_d = beat_q + 4'd1;
               if (beat_q == 4'd7) begin
                  beat_d  = 4'd0;
                  resp_d  = 1'b1;
                  state_d = WR_ACK;
               end
            end
         end
         WR_ACK: state_d = IDLE;
         RD_WAIT: begin
            if (lat_q <= 3'd1) begin
               lat_d   = 3'd0;
               state_d = RD_BURST;
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         RD_BURST: begin
            // Beats 8 and 9 drain the two-stage read pipeline before returning to IDLE
            rd_en_c = (beat_q < 4'd8);
            beat_d  = beat_q + 4'd1;
            if (beat_q == 4'd9) begin
               beat_d  = 4'd0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      rd_vld_d = rd_en_c;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         lat_q    <= '0;
         line_q   <= '0;
         rd_vld_q <= 1'b0;
         resp_q   <= 1'b0;
         rdata_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         lat_q    <= lat_d;
         line_q   <= line_d;
         rd_vld_q <= rd_vld_d;
         resp_q   <= resp_d;
         rdata_q  <= rdata_d;
         error_q  <= error_d;
      end
   end

   // Storage array: no reset so contents survive rst and map onto block RAM
   always_ff @(posedge clk) begin
      if (we_c) mem[waddr_c] <= address_data_bus_c_to_m;
      if (rd_en_c) mem_rd_q <= mem[raddr_c];
   end

   assign address_data_bus_m_to_c = rdata_q;
   assign resp_m_to_c             = resp_q;
   assign error                   = error_q;

endmodule

// File: tb/tb_fpga_bram_responder.sv
// Directed bench for fpga_bram_responder (DEPTH_WORDS=1024, READ_LATENCY=2).
module tb_fpga_bram_responder;

   typedef logic [7:0][31:0] line_t;
   typedef logic [7:0][4:0]  cyc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bus_in;
   logic        addr_on, data_on, rd_en, wr_en;
   logic [31:0] bus_out;
   logic        resp, err;

   int checks = 0;
   int errors = 0;

   line_t w40, w20;

   always #5 clk = ~clk;

   fpga_bram_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(2)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .address_data_bus_c_to_m (bus_in),
      .address_on_c_to_m       (addr_on),
      .data_on_c_to_m          (data_on),
      .read_en_c_to_m          (rd_en),
      .write_en_c_to_m         (wr_en),
      .address_data_bus_m_to_c (bus_out),
      .resp_m_to_c             (resp),
      .error                   (err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      addr_on = 1'b0;
      data_on = 1'b0;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      bus_in  = 32'hBAD0_BAD0;
   endtask

   // Drives one line write; reports what was seen in the ack cycle and around it
   task automatic do_write(input logic [31:0] addr, input line_t w, input int gap_after,
                           input int gap_len, output logic ack_resp, output logic [31:0] ack_bus,
                           output logic early, output logic tail_resp);
      early   = 1'b0;
      bus_in  = addr;
      addr_on = 1'b1;
      wr_en   = 1'b1;
      step();
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         bus_in  = w[i];
         data_on = 1'b1;
         if (resp !== 1'b0) early = 1'b1;
         step();
         idle_inputs();
         if (i == gap_after) begin
            for (int g = 0; g < gap_len; g++) begin
               if (resp !== 1'b0) early = 1'b1;
               step();
            end
         end
      end
      ack_resp = resp;
      ack_bus  = bus_out;
      step();
      tail_resp = resp;
   endtask

   // Issues a read in the current cycle and captures beats over cycles 1..10
   task automatic do_read(input logic [31:0] addr, output line_t got, output cyc_t cyc,
                          output int nbeats, output logic leak, output logic tail_resp);
      int n;
      n    = 0;
      leak = 1'b0;
      got  = {8{32'hDEAD_BEEF}};
      cyc  = '0;
      bus_in  = addr;
      addr_on = 1'b1;
      rd_en   = 1'b1;
      step();
      idle_inputs();
      for (int c = 1; c <= 10; c++) begin
         if (resp === 1'b1) begin
            if (n < 8) begin
               got[n] = bus_out;
               cyc[n] = 5'(c);
            end
            n++;
         end else if (bus_out !== 32'h0) begin
            leak = 1'b1;
         end
         step();
      end
      tail_resp = resp;
      if (bus_out !== 32'h0) leak = 1'b1;
      nbeats = n;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      #2;
      checks++;
      if (resp !== 1'b0 || err !== 1'b0 || bus_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs resp=%b err=%b bus=%h expected 0 0 0", resp, err, bus_out);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      step();
   endtask

   task automatic test_write_read();
      logic ack_resp, early, tail, leak;
      logic [31:0] ack_bus;
      line_t got;
      cyc_t cyc;
      int n;
      do_write(32'h0000_0040, w40, -1, 0, ack_resp, ack_bus, early, tail);
      checks++;
      if (ack_resp !== 1'b1 || ack_bus !== 32'h0 || early !== 1'b0 || tail !== 1'b0) begin
         errors++;
         $display("FAIL wr40_ack resp=%b bus=%h early=%b tail=%b expected 1 0 0 0",
                  ack_resp, ack_bus, early, tail);
      end
      do_read(32'h0000_0040, got, cyc, n, leak, tail);
      checks++;
      if (n !== 8 || leak !== 1'b0 || tail !== 1'b0) begin
         errors++;
         $display("FAIL rd40_shape beats=%0d leak=%b tail=%b expected 8 0 0", n, leak, tail);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (got[i] !== w40[i] || cyc[i] !== 5'(3 + i)) begin
            errors++;
            $display("FAIL rd40_beat%0d data=%h cycle=%0d expected %h cycle %0d",
                     i, got[i], cyc[i], w40[i], 3 + i);
         end
      end
   endtask

   task automatic test_gap_write();
      logic ack_resp, early, tail, leak;
      logic [31:0] ack_bus;
      line_t got;
      cyc_t cyc;
      int n;
      do_write(32'h0000_0020, w20, 3, 2, ack_resp, ack_bus, early, tail);
      checks++;
      if (ack_resp !== 1'b1 || ack_bus !== 32'h0 || early !== 1'b0 || tail !== 1'b0) begin
         errors++;
         $display("FAIL wr20_gap_ack resp=%b bus=%h early=%b tail=%b expected 1 0 0 0",
                  ack_resp, ack_bus, early, tail);
      end
      do_read(32'h0000_0020, got, cyc, n, leak, tail);
      checks++;
      if (n !== 8 || leak !== 1'b0 || tail !== 1'b0) begin
         errors++;
         $display("FAIL rd20_shape beats=%0d leak=%b tail=%b expected 8 0 0", n, leak, tail);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (got[i] !== w20[i] || cyc[i] !== 5'(3 + i)) begin
            errors++;
            $display("FAIL rd20_beat%0d data=%h cycle=%0d expected %h cycle %0d",
                     i, got[i], cyc[i], w20[i], 3 + i);
         end
      end
   endtask

   task automatic test_bad_enables();
      logic any_resp, leak, tail;
      line_t got;
      cyc_t cyc;
      int n;
      // Three illegal IDLE patterns: both enables, neither enable, data_on with a read request
      for (int k = 0; k < 3; k++) begin
         bus_in  = 32'h0000_0040;
         addr_on = 1'b1;
         rd_en   = (k != 1);
         wr_en   = (k == 0);
         data_on = (k == 2);
         step();
         idle_inputs();
         checks++;
         if (err !== 1'b1 || resp !== 1'b0) begin
            errors++;
            $display("FAIL bad_req%0d_pulse err=%b resp=%b expected 1 0", k, err, resp);
         end
         any_resp = 1'b0;
         step();
         checks++;
         if (err !== 1'b0) begin
            errors++;
            $display("FAIL bad_req%0d_one_cycle err=%b expected 0", k, err);
         end
         for (int c = 0; c < 10; c++) begin
            if (resp !== 1'b0) any_resp = 1'b1;
            step();
         end
         checks++;
         if (any_resp !== 1'b0) begin
            errors++;
            $display("FAIL bad_req%0d_no_resp resp_seen=%b expected 0", k, any_resp);
         end
      end
      data_on = 1'b1;
      bus_in  = 32'h5555_5555;
      step();
      idle_inputs();
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL idle_data_err err=%b expected 1", err);
      end
      step();
      do_read(32'h0000_0040, got, cyc, n, leak, tail);
      checks++;
      if (n !== 8 || got !== w40 || cyc[0] !== 5'd3) begin
         errors++;
         $display("FAIL bad_req_then_read beats=%0d beat0=%h cycle0=%0d expected 8 %h 3",
                  n, got[0], cyc[0], w40[0]);
      end
   endtask

   task automatic test_read_collision();
      line_t got;
      logic [12:0] err_seen;
      int n;
      logic late;
      n = 0;
      got = {8{32'hDEAD_BEEF}};
      err_seen = '0;
      late = 1'b0;
      bus_in  = 32'h0000_0040;
      addr_on = 1'b1;
      rd_en   = 1'b1;
      step();
      idle_inputs();
      for (int c = 1; c <= 12; c++) begin
         if (c == 5) begin
            bus_in  = 32'h0000_0020;
            addr_on = 1'b1;
            rd_en   = 1'b1;
         end
         if (err === 1'b1) err_seen[c] = 1'b1;
         if (resp === 1'b1) begin
            if (c < 3 || c > 10) late = 1'b1;
            else begin
               got[c-3] = bus_out;
               n++;
            end
         end
         step();
         idle_inputs();
      end
      checks++;
      if (err_seen !== 13'h0040) begin
         errors++;
         $display("FAIL collision_err cycles=%b expected %b", err_seen, 13'h0040);
      end
      checks++;
      if (n !== 8 || late !== 1'b0 || got !== w40) begin
         errors++;
         $display("FAIL collision_burst beats=%0d stray=%b beat7=%h expected 8 0 %h",
                  n, late, got[7], w40[7]);
      end
   endtask

   task automatic test_reset_mid_write();
      logic ack_resp, early, tail, leak, any_resp;
      logic [31:0] ack_bus;
      line_t old_w, new_w, exp_w, got;
      cyc_t cyc;
      int n;
      for (int i = 0; i < 8; i++) begin
         old_w[i] = 32'h0100_0000 + 32'(i);
         new_w[i] = 32'h2222_0000 + 32'(i);
         exp_w[i] = (i < 4) ? new_w[i] : old_w[i];
      end
      do_write(32'h0000_0100, old_w, -1, 0, ack_resp, ack_bus, early, tail);
      checks++;
      if (ack_resp !== 1'b1) begin
         errors++;
         $display("FAIL wr100_old_ack resp=%b expected 1", ack_resp);
      end
      bus_in  = 32'h0000_0100;
      addr_on = 1'b1;
      wr_en   = 1'b1;
      step();
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         bus_in  = new_w[i];
         data_on = 1'b1;
         step();
         idle_inputs();
      end
      bus_in  = new_w[4];
      data_on = 1'b1;
      rst     = 1'b0;
      #1;
      checks++;
      if (resp !== 1'b0 || err !== 1'b0 || bus_out !== 32'h0) begin
         errors++;
         $display("FAIL async_reset resp=%b err=%b bus=%h expected 0 0 0", resp, err, bus_out);
      end
      any_resp = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (resp !== 1'b0) any_resp = 1'b1;
      end
      idle_inputs();
      checks++;
      if (any_resp !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_ack resp_seen=%b expected 0", any_resp);
      end
      @(negedge clk);
      rst = 1'b1;
      do_read(32'h0000_0100, got, cyc, n, leak, tail);
      checks++;
      if (n !== 8 || cyc[0] !== 5'd3 || leak !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_read beats=%0d cycle0=%0d leak=%b expected 8 3 0",
                  n, cyc[0], leak);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (got[i] !== exp_w[i]) begin
            errors++;
            $display("FAIL aborted_line_beat%0d data=%h expected %h", i, got[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_alias();
      logic leak, tail;
      line_t got;
      cyc_t cyc;
      int n;
      do_read(32'h0000_8040, got, cyc, n, leak, tail);
      checks++;
      if (n !== 8 || got !== w40 || cyc[7] !== 5'd10) begin
         errors++;
         $display("FAIL alias_8040 beats=%0d beat0=%h beat7=%h expected 8 %h %h",
                  n, got[0], got[7], w40[0], w40[7]);
      end
   endtask

   task automatic test_back_to_back();
      logic ack_resp, early, tail, leak;
      logic [31:0] ack_bus;
      line_t w60, got;
      cyc_t cyc;
      int n;
      for (int i = 0; i < 8; i++) w60[i] = 32'h6060_0000 ^ (32'(i) << 4);
      do_write(32'h0000_0060, w60, -1, 0, ack_resp, ack_bus, early, tail);
      do_read(32'h0000_0060, got, cyc, n, leak, tail);
      checks++;
      if (ack_resp !== 1'b1 || n !== 8 || got !== w60 || cyc[0] !== 5'd3) begin
         errors++;
         $display("FAIL b2b_write_read ack=%b beats=%0d beat0=%h cycle0=%0d expected 1 8 %h 3",
                  ack_resp, n, got[0], cyc[0], w60[0]);
      end
      do_read(32'h0000_0020, got, cyc, n, leak, tail);
      checks++;
      if (n !== 8 || got !== w20 || cyc[0] !== 5'd3 || tail !== 1'b0) begin
         errors++;
         $display("FAIL b2b_read_read beats=%0d beat0=%h cycle0=%0d tail=%b expected 8 %h 3 0",
                  n, got[0], cyc[0], tail, w20[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         w40[i] = 32'h1111_1111 * 32'(i + 1);
         w20[i] = 32'hA000_0000 + 32'(i * 3);
      end
      test_reset();
      test_write_read();
      test_gap_write();
      test_bad_enables();
      test_read_collision();
      test_reset_mid_write();
      test_alias();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation exceeded 200000 time units");
      $fatal(1);
   end

endmodule
